// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer monitor and alarm generator.
// Holds FSM states, zone codes, the nominal pulse length and a zone decoder.
package buzzer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEASURE  = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ZONE_NONE = 2'd0,
      ZONE_1    = 2'd1,
      ZONE_2    = 2'd2,
      ZONE_3    = 2'd3
   } zone_t;

   localparam int PULSE_LEN_DEF = 31;
   localparam int LEN_W         = 6;

   // Maps a one-hot buzzer line to its zone code.
   function automatic zone_t zone_of(input logic [2:0] oh);
      zone_t z;
      z = ZONE_NONE;
      unique case (1'b1)
         oh[0]:   z = ZONE_1;
         oh[1]:   z = ZONE_2;
         oh[2]:   z = ZONE_3;
         default: z = ZONE_NONE;
      endcase
      return z;
   endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (sync, active-low), inc, clr (priority), cnt.
module sat_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/buzzer_monitor.sv
// Checks buzzer pulses for length and exclusivity; counts valid events per zone.
// Ports: clk, rst_n, buzz[2:0], clear -> evt_valid, evt_zone, err_len,
//        err_ovl, cnt1..cnt3.
module buzzer_monitor
   import buzzer_pkg::*;
#(
   parameter int PULSE_LEN = PULSE_LEN_DEF,
   parameter int TOL       = 1,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       buzz,
   input  logic             clear,
   output logic             evt_valid,
   output logic [1:0]       evt_zone,
   output logic             err_len,
   output logic             err_ovl,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
);

   localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(PULSE_LEN - TOL);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PULSE_LEN + TOL);
   localparam logic [LEN_W-1:0] LEN_LAST = {LEN_W{1'b1}} - 1'b1;

   state_t           state_q;
   logic [2:0]       line_q;
   logic [LEN_W-1:0] len_q;

   logic       one_hot;
   logic       done;
   logic       len_ok;
   logic [2:0] inc;

   always_comb begin
      one_hot = 1'b0;
      done    = 1'b0;
      len_ok  = 1'b0;
      inc     = 3'b000;
      one_hot = (buzz != 3'b000) && ((buzz & (buzz - 3'd1)) == 3'b000);
      done    = (state_q == MEASURE) && (buzz == 3'b000);
      len_ok  = (len_q >= LEN_MIN) && (len_q <= LEN_MAX);
      // Counter bumps land on the same edge that raises evt_valid.
      inc     = {3{done && len_ok}} & line_q;
   end

   // Clear is applied first so a newly detected error overrides it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         line_q    <= 3'b000;
         len_q     <= '0;
         evt_valid <= 1'b0;
         evt_zone  <= ZONE_NONE;
         err_len   <= 1'b0;
         err_ovl   <= 1'b0;
      end else begin
         evt_valid <= 1'b0;
         if (clear) begin
            evt_zone <= ZONE_NONE;
            err_len  <= 1'b0;
            err_ovl  <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (one_hot) begin
                  state_q <= MEASURE;
                  line_q  <= buzz;
                  len_q   <= LEN_W'(1);
               end else if (buzz != 3'b000) begin
                  err_ovl <= 1'b1;
                  state_q <= WAIT_LOW;
               end
            end
            MEASURE: begin
               if (buzz == 3'b000) begin
                  state_q <= IDLE;
                  if (len_ok) begin
                     evt_valid <= 1'b1;
                     if (!clear) evt_zone <= zone_of(line_q);
                  end else begin
                     err_len <= 1'b1;
                  end
               end else if (buzz == line_q) begin
                  len_q <= len_q + 1'b1;
                  // Length counter hits its ceiling: abandon the pulse.
                  if (len_q == LEN_LAST) begin
                     err_len <= 1'b1;
                     state_q <= WAIT_LOW;
                  end
               end else begin
                  err_ovl <= 1'b1;
                  state_q <= WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               if (buzz == 3'b000) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   sat_cnt #(.W(CNT_W)) u_cnt1 (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc[0]),
      .clr  (clear),
      .cnt  (cnt1)
   );

   sat_cnt #(.W(CNT_W)) u_cnt2 (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc[1]),
      .clr  (clear),
      .cnt  (cnt2)
   );

   sat_cnt #(.W(CNT_W)) u_cnt3 (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc[2]),
      .clr  (clear),
      .cnt  (cnt3)
   );

endmodule

// File: tb/tb_buzzer_monitor.sv
// Directed self-checking bench for buzzer_monitor.
// Drives pulses of chosen lengths and checks events, errors and counters.
module tb_buzzer_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] buzz;
   logic       clear;
   logic       evt_valid;
   logic [1:0] evt_zone;
   logic       err_len;
   logic       err_ovl;
   logic [3:0] cnt1;
   logic [3:0] cnt2;
   logic [3:0] cnt3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   buzzer_monitor dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .buzz     (buzz),
      .clear    (clear),
      .evt_valid(evt_valid),
      .evt_zone (evt_zone),
      .err_len  (err_len),
      .err_ovl  (err_ovl),
      .cnt1     (cnt1),
      .cnt2     (cnt2),
      .cnt3     (cnt3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // High for n samples, then one low sample; clr is driven on that low edge.
   task automatic pulse(input logic [2:0] bits, input int n,
                        input logic clr);
      buzz = bits;
      repeat (n) tick();
      buzz  = 3'b000;
      clear = clr;
      tick();
      clear = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      buzz  = 3'b000;
      clear = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_valid", evt_valid, 0);
      chk("rst_zone", evt_zone, 0);
      chk("rst_elen", err_len, 0);
      chk("rst_eovl", err_ovl, 0);
      chk("rst_cnts", {cnt1, cnt2, cnt3}, 0);

      // Nominal zone-1 pulse
      tick();
      pulse(3'b001, 31, 1'b0);
      chk("z1_valid", evt_valid, 1);
      chk("z1_zone", evt_zone, 1);
      chk("z1_cnt1", cnt1, 1);
      chk("z1_errs", {err_len, err_ovl}, 0);
      tick();
      chk("z1_strobe_end", evt_valid, 0);

      // Short zone-3 pulse, then long-but-ok
      pulse(3'b100, 29, 1'b0);
      chk("z3s_valid", evt_valid, 0);
      chk("z3s_elen", err_len, 1);
      chk("z3s_cnt3", cnt3, 0);
      tick();
      pulse(3'b100, 32, 1'b0);
      chk("z3l_valid", evt_valid, 1);
      chk("z3l_zone", evt_zone, 3);
      chk("z3l_cnt3", cnt3, 1);
      tick();

      // Tolerance edges: 30 accepted, 33 rejected
      do_clear();
      chk("clr_all", {evt_zone, err_len, err_ovl, cnt1, cnt2, cnt3}, 0);
      pulse(3'b001, 30, 1'b0);
      chk("b30_valid", evt_valid, 1);
      chk("b30_cnt1", cnt1, 1);
      tick();
      pulse(3'b010, 33, 1'b0);
      chk("b33_valid", evt_valid, 0);
      chk("b33_elen", err_len, 1);
      chk("b33_cnt2", cnt2, 0);
      tick();

      // Overlap mid-pulse, then a clean zone-2 pulse
      do_clear();
      buzz = 3'b010;
      repeat (10) tick();
      buzz = 3'b011;
      tick();
      chk("ovl_set", err_ovl, 1);
      repeat (3) tick();
      buzz = 3'b000;
      tick();
      chk("ovl_noevt", evt_valid, 0);
      chk("ovl_cnt2", cnt2, 0);
      tick();
      pulse(3'b010, 31, 1'b0);
      chk("ovl_z2_valid", evt_valid, 1);
      chk("ovl_z2_cnt2", cnt2, 1);
      chk("ovl_sticky", err_ovl, 1);
      tick();

      // Two lines rising together from idle
      do_clear();
      buzz = 3'b110;
      tick();
      chk("idle_ovl", err_ovl, 1);
      buzz = 3'b000;
      tick();
      tick();

      // Saturation
      do_clear();
      for (int i = 0; i < 17; i++) begin
         pulse(3'b001, 31, 1'b0);
         tick();
      end
      chk("sat_cnt1", cnt1, 15);
      chk("sat_zone", evt_zone, 1);
      do_clear();
      chk("sat_clr", {evt_zone, err_len, err_ovl, cnt1, cnt2, cnt3}, 0);

      // Stuck-high line hits length ceiling
      buzz = 3'b001;
      repeat (70) tick();
      chk("stuck_elen", err_len, 1);
      buzz = 3'b000;
      tick();
      chk("stuck_noevt", evt_valid, 0);
      chk("stuck_cnt1", cnt1, 0);
      tick();
      pulse(3'b001, 31, 1'b0);
      chk("stuck_recover", {evt_valid, cnt1}, {1'b1, 4'd1});
      tick();

      // Reset in the middle of a pulse
      buzz = 3'b001;
      repeat (14) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_outs",
          {evt_valid, evt_zone, err_len, err_ovl, cnt1, cnt2, cnt3}, 0);
      repeat (16) tick();
      buzz = 3'b000;
      tick();
      chk("mrst_tail_valid", evt_valid, 0);
      chk("mrst_tail_elen", err_len, 1);
      tick();

      // Clear together with event completion
      do_clear();
      pulse(3'b100, 31, 1'b1);
      chk("cevt_valid", evt_valid, 1);
      chk("cevt_zone", evt_zone, 0);
      chk("cevt_cnt3", cnt3, 0);
      tick();

      // Clear together with a length error
      pulse(3'b010, 20, 1'b1);
      chk("cerr_elen", err_len, 1);
      chk("cerr_valid", evt_valid, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/buzzer_monitor.md
BUZZER_MONITOR -- requirements
Module: buzzer_monitor

Interface
REQ-001 Parameter PULSE_LEN, default 31: nominal buzzer pulse length in clock cycles.
REQ-002 Parameter TOL, default 1: accepted deviation, in cycles, from PULSE_LEN.
REQ-003 Parameter CNT_W, default 4: width of each per-zone event counter.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 buzz  input  3  buzzer lines from the alarm block; bit0=zone1, bit1=zone2, bit2=zone3; same clock domain, sampled directly.
REQ-007 clear  input  1  synchronous clear of counters and sticky errors.
REQ-008 evt_valid  output  1  one-cycle strobe for a well-formed pulse.
REQ-009 evt_zone  output  2  zone of last valid event (1..3; 0 = none since reset/clear).
REQ-010 err_len  output  1  sticky; pulse length out of tolerance.
REQ-011 err_ovl  output  1  sticky; more than one line high, or active line changed mid-pulse.
REQ-012 cnt1, cnt2, cnt3  output  CNT_W each  saturating valid-event counts per zone.

Function
REQ-013 FSM states SHALL be IDLE, MEASURE, WAIT_LOW.
REQ-014 IDLE: buzz=000 -> stay; exactly one bit high -> MEASURE, latch that line, length counter L=1; two or more bits high -> set err_ovl, go WAIT_LOW.
REQ-015 MEASURE: buzz equal to latched one-hot -> L=L+1; buzz=000 -> evaluate pulse, go IDLE; any other nonzero value -> set err_ovl, go WAIT_LOW.
REQ-016 L SHALL be 6 bits; if L reaches 63 while the line is still high, err_len SHALL be set and FSM SHALL go WAIT_LOW (no event).
REQ-017 WAIT_LOW: stay until buzz=000, then IDLE; no events generated from that pulse.
REQ-018 Evaluation: PULSE_LEN-TOL <= L <= PULSE_LEN+TOL -> valid event; otherwise set err_len, no event.
REQ-019 Valid event: evt_valid high for exactly the cycle after the first low sample; evt_zone updated to the zone code in the same cycle; matching counter incremented by 1.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 (15 by default), never wrap.
REQ-021 A new pulse SHALL be accepted starting in the cycle following return to IDLE (minimum one low cycle between pulses).
REQ-022 clear=1: counters->0, err_len->0, err_ovl->0, evt_zone->0 on the next edge; FSM state and L unaffected.
REQ-023 clear coinciding with event completion: clear wins for counters, errors, and evt_zone; evt_valid still pulses.
REQ-024 clear coinciding with an error condition: error flag SHALL end set (new error wins over clear).
REQ-025 Zero output latency beyond REQ-019; all outputs registered.

Reset
REQ-026 rst_n=0 on a rising edge: state IDLE, L=0, evt_valid=0, evt_zone=0, err_len=0, err_ovl=0, cnt1..cnt3=0.
REQ-027 Reset mid-pulse SHALL discard the pulse; after release with line still high, FSM SHALL start a new MEASURE from L=1 on the next high sample.

Structure
REQ-028 Shared package buzzer_pkg SHALL hold the FSM state enum, zone codes (NONE=0, Z1=1, Z2=2, Z3=3), and the PULSE_LEN default shared with the alarm generator.
REQ-029 One sub-module sat_cnt (parameterised width, inc, clr, saturating) SHALL be instantiated three times for cnt1..cnt3.

Verification
REQ-030 buzz=001 for 31 cycles then 000 -> evt_valid one cycle after first low sample, evt_zone=1, cnt1=1, no errors.
REQ-031 buzz=100 for 29 cycles, then 000 -> err_len=1, no evt_valid, cnt3=0; buzz=100 for 32 cycles -> valid event, cnt3=1.
REQ-032 buzz=010 for 10 cycles, then 011 -> err_ovl=1; no event until buzz=000, then a correct 31-cycle 010 pulse -> cnt2=1, err_ovl still 1.
REQ-033 Seventeen 31-cycle zone-1 pulses -> cnt1 saturates at 15; clear pulse -> all counters 0, errors 0, evt_zone=0.
REQ-034 buzz=001 held 70 cycles -> err_len set at L=63, no event; line drop -> IDLE.
REQ-035 rst_n low for one cycle at cycle 15 of a 31-cycle pulse -> all outputs reset, remaining 16-cycle tail flagged err_len, no event.
